// File: rtl/meas_reader_if.sv
// Bus bundle for meas_reader: measurement write strobe/data, bus-side read
// request/response and FIFO/overflow status.
//   slave  : the meas_reader side (consumes requests, drives responses/status)
//   master : the requester side (drives requests, observes responses/status)
interface meas_reader_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic          reg_wr_en_i;
   logic [63:0]   reg_wr_data_i;
   logic          rd_req_i;
   logic          rd_sel_i;
   logic          ovf_clr_i;
   logic [31:0]   rd_data_o;
   logic          rd_valid_o;
   logic          empty_o;
   logic          full_o;
   logic [LW-1:0] level_o;
   logic          ovf_o;
   logic [15:0]   drop_cnt_o;

   modport slave (
      input  reg_wr_en_i, reg_wr_data_i, rd_req_i, rd_sel_i, ovf_clr_i,
      output rd_data_o, rd_valid_o, empty_o, full_o, level_o, ovf_o, drop_cnt_o
   );

   modport master (
      output reg_wr_en_i, reg_wr_data_i, rd_req_i, rd_sel_i, ovf_clr_i,
      input  rd_data_o, rd_valid_o, empty_o, full_o, level_o, ovf_o, drop_cnt_o
   );
endinterface

// File: rtl/meas_reader.sv
// Measurement result reader: buffers 64-bit results (reference count in the
// upper word, signal count in the lower word) in a DEPTH-entry FIFO and serves
// them to a 32-bit bus. A pop read returns the lower word and latches the upper
// word into a hold register, which a following held read returns.
// Ports:
//   clk_i   : system clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : meas_reader_if slave modport (write, read, status signals)
module meas_reader #(
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   meas_reader_if.slave bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;
   localparam logic [PW-1:0] PtrOne = 1;
   localparam logic [LW-1:0] LvlFull = LW'(DEPTH);

   logic [63:0]   mem [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [LW-1:0] level_q, level_d;
   logic          empty_q, full_q;
   logic [31:0]   hold_q, hold_d;
   logic [31:0]   rd_data_q, rd_data_d;
   logic          rd_valid_q;
   logic          ovf_q, ovf_d;
   logic [15:0]   drop_cnt_q, drop_cnt_d;

   logic pop_ok, push_ok, drop;
   logic [63:0] head_word;

   assign head_word = mem[head_q];

   // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
   always_comb begin
      pop_ok  = bus.rd_req_i & ~bus.rd_sel_i & ~empty_q;
      push_ok = bus.reg_wr_en_i & (~full_q | pop_ok);
      drop    = bus.reg_wr_en_i & full_q & ~pop_ok;
   end

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      level_d    = level_q;
      hold_d     = hold_q;
      rd_data_d  = rd_data_q;
      ovf_d      = ovf_q;
      drop_cnt_d = drop_cnt_q;

      if (push_ok) tail_d = tail_q + PtrOne;
      if (pop_ok)  head_d = head_q + PtrOne;
      level_d = level_q + LW'(push_ok) - LW'(pop_ok);

      if (bus.rd_req_i) begin
         if (bus.rd_sel_i) begin
            rd_data_d = hold_q;
         end else if (empty_q) begin
            // Empty pop returns zero and clears the hold word; never bypasses a push.
            rd_data_d = 32'h0;
            hold_d    = 32'h0;
         end else begin
            rd_data_d = head_word[31:0];
            hold_d    = head_word[63:32];
         end
      end

      // A drop coincident with a clear leaves exactly one counted drop.
      if (drop) begin
         ovf_d = 1'b1;
         if (bus.ovf_clr_i)              drop_cnt_d = 16'd1;
         else if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end else if (bus.ovf_clr_i) begin
         ovf_d      = 1'b0;
         drop_cnt_d = 16'd0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         head_q     <= '0;
         tail_q     <= '0;
         level_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         hold_q     <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         level_q    <= level_d;
         empty_q    <= (level_d == '0);
         full_q     <= (level_d == LvlFull);
         hold_q     <= hold_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= bus.rd_req_i;
         ovf_q      <= ovf_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage is not reset; entries are only read after being written.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem[tail_q] <= bus.reg_wr_data_i;
   end

   assign bus.rd_data_o  = rd_data_q;
   assign bus.rd_valid_o = rd_valid_q;
   assign bus.empty_o    = empty_q;
   assign bus.full_o     = full_q;
   assign bus.level_o    = level_q;
   assign bus.ovf_o      = ovf_q;
   assign bus.drop_cnt_o = drop_cnt_q;
endmodule

// File: tb/tb_meas_reader.sv
// Directed self-checking bench for meas_reader (DEPTH = 4).
module tb_meas_reader;
   localparam int unsigned DEPTH = 4;

   logic clk_i = 1'b0;
   logic rst_n_i = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   meas_reader_if #(.DEPTH(DEPTH)) bus ();

   meas_reader #(.DEPTH(DEPTH)) dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .bus     (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock with the given inputs; returns 1 time unit after the edge.
   task automatic cyc(input logic wr, input logic [63:0] d, input logic rd,
                      input logic sel, input logic clr);
      bus.reg_wr_en_i   = wr;
      bus.reg_wr_data_i = d;
      bus.rd_req_i      = rd;
      bus.rd_sel_i      = sel;
      bus.ovf_clr_i     = clr;
      @(posedge clk_i);
      #1;
      bus.reg_wr_en_i = 1'b0;
      bus.rd_req_i    = 1'b0;
      bus.rd_sel_i    = 1'b0;
      bus.ovf_clr_i   = 1'b0;
   endtask

   task automatic push(input logic [63:0] d);
      cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop_chk(input string tag, input logic [31:0] exp);
      cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      chk({tag, "_valid"}, 64'(bus.rd_valid_o), 64'h1);
      chk(tag, 64'(bus.rd_data_o), 64'(exp));
   endtask

   task automatic held_chk(input string tag, input logic [31:0] exp);
      cyc(1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
      chk({tag, "_valid"}, 64'(bus.rd_valid_o), 64'h1);
      chk(tag, 64'(bus.rd_data_o), 64'(exp));
   endtask

   initial begin
      bus.reg_wr_en_i   = 1'b0;
      bus.reg_wr_data_i = 64'h0;
      bus.rd_req_i      = 1'b0;
      bus.rd_sel_i      = 1'b0;
      bus.ovf_clr_i     = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_empty", 64'(bus.empty_o), 64'h1);
      chk("rst_full", 64'(bus.full_o), 64'h0);
      chk("rst_level", 64'(bus.level_o), 64'h0);
      chk("rst_ovf", 64'(bus.ovf_o), 64'h0);
      chk("rst_drop", 64'(bus.drop_cnt_o), 64'h0);
      chk("rst_valid", 64'(bus.rd_valid_o), 64'h0);
      chk("rst_data", 64'(bus.rd_data_o), 64'h0);
      rst_n_i = 1'b1;

      // Basic push, pop read, held read
      push(64'h0000_1000_0000_0064);
      chk("b_level", 64'(bus.level_o), 64'h1);
      chk("b_empty0", 64'(bus.empty_o), 64'h0);
      pop_chk("b_pop", 32'h64);
      chk("b_empty1", 64'(bus.empty_o), 64'h1);
      held_chk("b_held", 32'h1000);
      cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      chk("b_idle_valid", 64'(bus.rd_valid_o), 64'h0);
      chk("b_idle_data", 64'(bus.rd_data_o), 64'h1000);

      // Overfill: DEPTH+2 pushes, two dropped
      for (int i = 0; i < DEPTH + 2; i++) push({32'hA0 + 32'(i), 32'h10 + 32'(i)});
      chk("o_full", 64'(bus.full_o), 64'h1);
      chk("o_level", 64'(bus.level_o), 64'(DEPTH));
      chk("o_ovf", 64'(bus.ovf_o), 64'h1);
      chk("o_drop", 64'(bus.drop_cnt_o), 64'h2);
      for (int i = 0; i < DEPTH; i++) pop_chk("o_pop", 32'h10 + 32'(i));
      held_chk("o_held", 32'hA3);
      chk("o_empty", 64'(bus.empty_o), 64'h1);

      // Full with simultaneous push and pop
      for (int i = 0; i < DEPTH; i++) push({32'hB0 + 32'(i), 32'h20 + 32'(i)});
      cyc(1'b1, {32'hB4, 32'h24}, 1'b1, 1'b0, 1'b0);
      chk("f_data", 64'(bus.rd_data_o), 64'h20);
      chk("f_level", 64'(bus.level_o), 64'(DEPTH));
      chk("f_full", 64'(bus.full_o), 64'h1);
      chk("f_drop", 64'(bus.drop_cnt_o), 64'h2);
      for (int i = 1; i <= DEPTH; i++) pop_chk("f_pop", 32'h20 + 32'(i));
      chk("f_empty", 64'(bus.empty_o), 64'h1);

      // Empty pop with coincident push: no bypass
      cyc(1'b1, {32'hCC, 32'h55}, 1'b1, 1'b0, 1'b0);
      chk("e_valid", 64'(bus.rd_valid_o), 64'h1);
      chk("e_data", 64'(bus.rd_data_o), 64'h0);
      chk("e_level", 64'(bus.level_o), 64'h1);
      held_chk("e_held0", 32'h0);
      pop_chk("e_pop", 32'h55);
      held_chk("e_held1", 32'hCC);

      // Overflow clear
      cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
      chk("c_ovf0", 64'(bus.ovf_o), 64'h0);
      chk("c_drop0", 64'(bus.drop_cnt_o), 64'h0);
      for (int i = 0; i < DEPTH; i++) push({32'hD0 + 32'(i), 32'h30 + 32'(i)});
      cyc(1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b1);
      chk("c_ovf1", 64'(bus.ovf_o), 64'h1);
      chk("c_drop1", 64'(bus.drop_cnt_o), 64'h1);
      cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
      chk("c_ovf2", 64'(bus.ovf_o), 64'h0);
      chk("c_drop2", 64'(bus.drop_cnt_o), 64'h0);

      // Reset mid-operation with 3 entries and a read in flight
      pop_chk("r_pop", 32'h30);
      chk("r_level", 64'(bus.level_o), 64'h3);
      bus.rd_req_i = 1'b1;
      bus.rd_sel_i = 1'b0;
      #2;
      rst_n_i = 1'b0;
      #1;
      chk("r_empty", 64'(bus.empty_o), 64'h1);
      chk("r_level0", 64'(bus.level_o), 64'h0);
      chk("r_valid", 64'(bus.rd_valid_o), 64'h0);
      chk("r_data", 64'(bus.rd_data_o), 64'h0);
      chk("r_full", 64'(bus.full_o), 64'h0);
      @(posedge clk_i);
      #1;
      bus.rd_req_i = 1'b0;
      rst_n_i = 1'b1;
      @(posedge clk_i);
      #1;
      chk("r_post_valid", 64'(bus.rd_valid_o), 64'h0);
      chk("r_post_empty", 64'(bus.empty_o), 64'h1);
      held_chk("r_post_held", 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
